ft245sync_dev: RTL and testbench
================================

# ft245sync_dev

Synthesizable FT245-style SyncFIFO device model for the FTDI end of the SyncFIFO pin interface. It drives nTXE/nRXF and the read data bus, and accepts OE#/RD#/WR# from the FPGA-side SyncFIFO controller. It bridges two internal FIFOs to host-side byte streams that stand in for the USB host. It is used in loopback builds and benches, where it is clocked by the same clock it exports as CLKOUT.

## Interface
Parameters:
- DEPTH_LOG2, 4: log2 depth of each FIFO (down: host->FPGA; up: FPGA->host).
- THROTTLE_PERIOD, 64: throttle cycle length in clocks (used only with the macro).
- THROTTLE_LEN, 4: clocks per period during which both flags are forced inactive (1 ≤ LEN < PERIOD).

Ports:
- i_clk  in  1  single clock; also the CLKOUT seen by the FPGA side; all logic on posedge.
- i_rst_n  in  1  reset; asynchronous assert, active-low.
- i_oe_n  in  1  FPGA OE#; low requests the device to drive the data bus.
- i_rd_n  in  1  FPGA RD#; low pops a down byte.
- i_wr_n  in  1  FPGA WR#; low pushes i_data into the up FIFO.
- i_siwu  in  1  SIWU; ignored.
- i_data  in  8  bus data driven by the FPGA.
- o_data  out  8  bus data from the device; equals the down FIFO head, or 8'h00 when the down FIFO is empty.
- o_data_oe  out  1  device tristate enable; equals !i_oe_n && i_rst_n.
- o_rxf_n  out  1  registered; low when the down FIFO holds data.
- o_txe_n  out  1  registered; low when the up FIFO has space.
- i_dn_data  in  8, i_dn_valid  in  1, o_dn_ready  out  1: host->FPGA stream; transfer on valid&&ready.
- o_up_data  out  8, o_up_valid  out  1, i_up_ready  in  1: FPGA->host stream, first-word-fall-through.
- o_err  out  3  sticky protocol errors; cleared only by reset.

## Operation
- Two circular FIFOs with DEPTH_LOG2-bit pointers that wrap and (DEPTH_LOG2+1)-bit counts.
- Down pop: at posedge when !i_rd_n && !i_oe_n && !o_rxf_n. The pop advances the read pointer and the next head appears on o_data after the edge.
- Down push: when i_dn_valid && o_dn_ready. o_dn_ready = (dn_count != DEPTH); there is no pass-through when full, even with a simultaneous pop.
- Up push: at posedge when !i_wr_n && !o_txe_n; the FIFO stores i_data. If WR# is low while o_txe_n is high, the byte is dropped and no error is flagged.
- Up pop: when o_up_valid && i_up_ready. o_up_valid = (up_count != 0).
- Push and pop in the same cycle on the same FIFO leave the count unchanged; the data order is preserved.
- Flag registers, updated at each posedge:
  - o_rxf_n <= (dn_count_next == 0) || throttle.
  - o_txe_n <= (up_count_next == DEPTH) || throttle.
  - The flags therefore reflect occupancy in the same cycle they are visible. After the last byte is popped, o_rxf_n is high on the next cycle.
- Sticky o_err bits:
  - [0] RD# low while OE# high.
  - [1] WR# low while OE# low (bus contention).
  - [2] RD# and WR# low simultaneously.
  - The bits are set at posedge and are independent of flag state.

## Timing
- While i_rst_n is low: o_rxf_n=1, o_txe_n=1, o_err=0, both FIFOs empty, o_data=8'h00, o_data_oe=0, o_dn_ready=0, o_up_valid=0.
- First posedge after reset release: o_txe_n=0, o_rxf_n=1.
- Host->pin latency: a byte accepted on i_dn at edge N gives o_rxf_n=0 and o_data valid after edge N. The FPGA can pop it at edge N+1.
- Pin->host latency: a byte written at edge N gives o_up_valid=1 after edge N.
- OE# to data: o_data_oe follows i_oe_n combinationally; there is no turnaround cycle inside the device.
- Sustained RD# low with data present gives one byte per clock.
- Reset mid-burst: all state clears asynchronously and in-flight bytes are discarded.

## Configuration
- FT245SYNC_DEV_THROTTLE_EN defined:
  - A free-running counter (reset 0, wraps at THROTTLE_PERIOD-1) forces both flags high while count ≥ THROTTLE_PERIOD-THROTTLE_LEN.
  - Pops and pushes are blocked in those cycles because they are gated on the flags.
  - This emulates USB packet gaps.
- Undefined: no counter exists and the throttle term is constant 0.

## Test plan
- Reset, then push 0x11,0x22,0x33 on i_dn; FPGA holds OE# low then RD# low for 3 clocks -> o_data reads 0x11,0x22,0x33 on consecutive edges; o_rxf_n goes high the cycle after the third pop.
- WR# low for 16 clocks with data 0x00..0x0F and i_up_ready=0 (DEPTH_LOG2=4) -> o_txe_n high after the 16th edge; a 17th byte 0xAA is dropped; draining returns 0x00..0x0F in order.
- Simultaneous down push and pin pop with a count of 1 -> o_rxf_n stays low and the count stays 1; wrap the pointers 3× with no data corruption.
- RD# low with OE# high -> o_err=3'b001; then WR# and RD# low with OE# low -> o_err=3'b111; assert reset mid-burst -> o_err=0 and both FIFOs empty.
- With FT245SYNC_DEV_THROTTLE_EN, PERIOD=8, LEN=2, continuous RD# -> exactly 6 pops per 8 clocks; both flags high in counter states 6 and 7.

Source files
------------

// File: rtl/ft245sync_dev.sv
// FT245 SyncFIFO device model: pin-side flags/bus bridged to host byte streams via two FIFOs (optional FT245SYNC_DEV_THROTTLE_EN).
// Latency: a byte pushed on either side is visible on the other side after one edge; flags are registered.
// Backpressure: o_dn_ready drops when the down FIFO is full; the up FIFO stops at nTXE high; host pops are first-word-fall-through.
module ft245sync_dev #(
    parameter int DEPTH_LOG2      = 4,
    parameter int THROTTLE_PERIOD = 64,
    parameter int THROTTLE_LEN    = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_oe_n,
    input  logic       i_rd_n,
    input  logic       i_wr_n,
    input  logic       i_siwu,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    output logic       o_data_oe,
    output logic       o_rxf_n,
    output logic       o_txe_n,
    input  logic [7:0] i_dn_data,
    input  logic       i_dn_valid,
    output logic       o_dn_ready,
    output logic [7:0] o_up_data,
    output logic       o_up_valid,
    input  logic       i_up_ready,
    output logic [2:0] o_err
);
    localparam int AW    = DEPTH_LOG2;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [7:0]    dn_mem_q [DEPTH];
    logic [7:0]    up_mem_q [DEPTH];
    logic [AW-1:0] dn_wp_q, dn_rp_q, up_wp_q, up_rp_q;
    logic [AW:0]   dn_cnt_q, dn_cnt_d, up_cnt_q, up_cnt_d;
    logic          rxf_n_q, rxf_n_d, txe_n_q, txe_n_d;
    logic [2:0]    err_q, err_d;
    logic          dn_push, dn_pop, up_push, up_pop;
    logic          throttle;
    logic          unused_siwu;

    assign unused_siwu = i_siwu;

`ifdef FT245SYNC_DEV_THROTTLE_EN
    localparam int TW = (THROTTLE_PERIOD > 1) ? $clog2(THROTTLE_PERIOD) : 1;
    logic [TW-1:0] thr_cnt_q, thr_cnt_d;

    always_comb begin
        thr_cnt_d = (thr_cnt_q == TW'(THROTTLE_PERIOD - 1)) ? '0 : thr_cnt_q + TW'(1);
    end

    // Throttle looks at the next counter value so the registered flags line up with the counter state.
    assign throttle = (thr_cnt_d >= TW'(THROTTLE_PERIOD - THROTTLE_LEN));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) thr_cnt_q <= '0;
        else          thr_cnt_q <= thr_cnt_d;
    end
`else
    assign throttle = 1'b0;
`endif

    assign o_dn_ready = i_rst_n && (dn_cnt_q != FULL);
    assign o_up_valid = (up_cnt_q != '0);
    assign o_data     = (dn_cnt_q != '0) ? dn_mem_q[dn_rp_q] : 8'h00;
    assign o_up_data  = up_mem_q[up_rp_q];
    assign o_data_oe  = !i_oe_n && i_rst_n;
    assign o_rxf_n    = rxf_n_q;
    assign o_txe_n    = txe_n_q;
    assign o_err      = err_q;

    always_comb begin
        dn_push  = i_dn_valid && o_dn_ready;
        dn_pop   = !i_rd_n && !i_oe_n && !rxf_n_q;
        up_push  = !i_wr_n && !txe_n_q;
        up_pop   = o_up_valid && i_up_ready;
        dn_cnt_d = dn_cnt_q + (AW+1)'(dn_push) - (AW+1)'(dn_pop);
        up_cnt_d = up_cnt_q + (AW+1)'(up_push) - (AW+1)'(up_pop);
        rxf_n_d  = (dn_cnt_d == '0) || throttle;
        txe_n_d  = (up_cnt_d == FULL) || throttle;
        err_d    = err_q | {!i_rd_n && !i_wr_n, !i_wr_n && !i_oe_n, !i_rd_n && i_oe_n};
    end

    // Storage has no reset: clearing the pointers and counts discards in-flight bytes.
    always_ff @(posedge i_clk) begin
        if (dn_push) dn_mem_q[dn_wp_q] <= i_dn_data;
        if (up_push) up_mem_q[up_wp_q] <= i_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dn_wp_q  <= '0;
            dn_rp_q  <= '0;
            up_wp_q  <= '0;
            up_rp_q  <= '0;
            dn_cnt_q <= '0;
            up_cnt_q <= '0;
            rxf_n_q  <= 1'b1;
            txe_n_q  <= 1'b1;
            err_q    <= '0;
        end else begin
            if (dn_push) dn_wp_q <= dn_wp_q + AW'(1);
            if (dn_pop)  dn_rp_q <= dn_rp_q + AW'(1);
            if (up_push) up_wp_q <= up_wp_q + AW'(1);
            if (up_pop)  up_rp_q <= up_rp_q + AW'(1);
            dn_cnt_q <= dn_cnt_d;
            up_cnt_q <= up_cnt_d;
            rxf_n_q  <= rxf_n_d;
            txe_n_q  <= txe_n_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_ft245sync_dev.sv
// Bench for ft245sync_dev: queue-based reference model with directed steps and a random phase.
module tb_ft245sync_dev;
    localparam int DL    = 4;
    localparam int DEPTH = 16;
    localparam int TP    = 8;
    localparam int TL    = 2;

    logic       clk = 1'b0;
    logic       rst_n, oe_n, rd_n, wr_n, siwu;
    logic [7:0] data_i, dn_data, o_data, o_up_data;
    logic       dn_valid, up_ready;
    logic       o_data_oe, o_rxf_n, o_txe_n, o_dn_ready, o_up_valid;
    logic [2:0] o_err;

    always #5 clk = ~clk;

    ft245sync_dev #(.DEPTH_LOG2(DL), .THROTTLE_PERIOD(TP), .THROTTLE_LEN(TL)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_oe_n(oe_n), .i_rd_n(rd_n), .i_wr_n(wr_n),
        .i_siwu(siwu), .i_data(data_i), .o_data(o_data), .o_data_oe(o_data_oe),
        .o_rxf_n(o_rxf_n), .o_txe_n(o_txe_n), .i_dn_data(dn_data), .i_dn_valid(dn_valid),
        .o_dn_ready(o_dn_ready), .o_up_data(o_up_data), .o_up_valid(o_up_valid),
        .i_up_ready(up_ready), .o_err(o_err)
    );

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] dn_q[$];
    logic [7:0] up_q[$];
    logic       rxf_m, txe_m;
    logic [2:0] err_m;
    int         cyc;
    int         pops;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic thr(input int c);
`ifdef FT245SYNC_DEV_THROTTLE_EN
        return (c % TP) >= (TP - TL);
`else
        return (c < 0);
`endif
    endfunction

    task automatic check_outputs();
        chk("rxf_n", o_rxf_n, rxf_m);
        chk("txe_n", o_txe_n, txe_m);
        chk("dn_ready", o_dn_ready, dn_q.size() < DEPTH);
        chk("up_valid", o_up_valid, up_q.size() != 0);
        chk("o_data", o_data, (dn_q.size() != 0) ? dn_q[0] : 8'h00);
        if (up_q.size() != 0) chk("up_head", o_up_data, up_q[0]);
        chk("err", o_err, err_m);
        chk("data_oe", o_data_oe, !oe_n);
    endtask

    // One clock: decide transfers from the model's own occupancy, then advance it.
    task automatic step();
        logic       dpop, dpush, upush, upop;
        logic [7:0] wbyte, dbyte;
        dpop  = !rd_n && !oe_n && !rxf_m;
        dpush = dn_valid && (dn_q.size() < DEPTH);
        upush = !wr_n && !txe_m;
        upop  = (up_q.size() != 0) && up_ready;
        wbyte = data_i;
        dbyte = dn_data;
        if (dpop) begin
            chk("pop_data", o_data, dn_q[0]);
            pops++;
        end
        if (upop) chk("up_data", o_up_data, up_q[0]);
        if (!rd_n && oe_n)   err_m[0] = 1'b1;
        if (!wr_n && !oe_n)  err_m[1] = 1'b1;
        if (!rd_n && !wr_n)  err_m[2] = 1'b1;
        @(posedge clk); #1;
        if (dpop)  void'(dn_q.pop_front());
        if (dpush) dn_q.push_back(dbyte);
        if (upop)  void'(up_q.pop_front());
        if (upush) up_q.push_back(wbyte);
        cyc++;
        rxf_m = (dn_q.size() == 0) || thr(cyc);
        txe_m = (up_q.size() == DEPTH) || thr(cyc);
        check_outputs();
    endtask

    task automatic idle_inputs();
        oe_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; dn_valid = 1'b0; up_ready = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        oe_n = 1'b0;
        #1;
        dn_q.delete(); up_q.delete();
        err_m = 3'b000; cyc = 0; rxf_m = 1'b1; txe_m = 1'b1;
        chk("rst_rxf", o_rxf_n, 1'b1);
        chk("rst_txe", o_txe_n, 1'b1);
        chk("rst_err", o_err, 3'b000);
        chk("rst_data", o_data, 8'h00);
        chk("rst_oe", o_data_oe, 1'b0);
        chk("rst_dn_ready", o_dn_ready, 1'b0);
        chk("rst_up_valid", o_up_valid, 1'b0);
        @(posedge clk); #1;
        idle_inputs();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1; siwu = 1'b0; data_i = 8'h00; dn_data = 8'h00;
        idle_inputs();
        err_m = 3'b000; rxf_m = 1'b1; txe_m = 1'b1; cyc = 0; pops = 0;
        #3;
        do_reset();
        step();
`ifndef FT245SYNC_DEV_THROTTLE_EN
        chk("first_txe", o_txe_n, 1'b0);
        chk("first_rxf", o_rxf_n, 1'b1);

        // Down path: three host bytes, then a 3-clock RD# burst.
        dn_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            dn_data = 8'(8'h11 * i);
            step();
        end
        dn_valid = 1'b0;
        oe_n = 1'b0;
        step();
        rd_n = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            chk("burst_data", o_data, 8'(8'h11 * i));
            step();
        end
        chk("rxf_after_drain", o_rxf_n, 1'b1);
        idle_inputs();

        // Up path: fill 16, drop a 17th, drain in order.
        wr_n = 1'b0;
        for (int i = 0; i < 16; i++) begin
            data_i = 8'(i);
            step();
        end
        chk("txe_full", o_txe_n, 1'b1);
        data_i = 8'hAA;
        step();
        wr_n = 1'b1;
        up_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_order", o_up_data, 8'(i));
            step();
        end
        chk("up_empty", o_up_valid, 1'b0);
        idle_inputs();

        // Count held at 1 by simultaneous push and pop while pointers wrap 3x.
        dn_valid = 1'b1; dn_data = 8'h55;
        step();
        oe_n = 1'b0; rd_n = 1'b0;
        for (int i = 0; i < 3 * DEPTH + 2; i++) begin
            dn_data = 8'(i + 8'h60);
            step();
            chk("hold_rxf", o_rxf_n, 1'b0);
        end
        dn_valid = 1'b0;
        step();
        chk("hold_drained", o_rxf_n, 1'b1);
        idle_inputs();

        // Sticky protocol errors.
        rd_n = 1'b0;
        step();
        chk("err_rd_no_oe", o_err, 3'b001);
        oe_n = 1'b0; wr_n = 1'b0;
        step();
        chk("err_all", o_err, 3'b111);
        idle_inputs();
        step();
        chk("err_sticky", o_err, 3'b111);
`endif

        // Load both FIFOs, then reset mid-burst.
        dn_valid = 1'b1; wr_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dn_data = 8'($urandom); data_i = 8'($urandom);
            step();
        end
        do_reset();
        chk("mid_rst_err", o_err, 3'b000);
        chk("mid_rst_up", o_up_valid, 1'b0);
        step();
        chk("post_rst_rxf", o_rxf_n, 1'b1);

`ifdef FT245SYNC_DEV_THROTTLE_EN
        dn_valid = 1'b1; oe_n = 1'b0; rd_n = 1'b0;
        for (int i = 0; i < 7; i++) step();
        pops = 0;
        for (int i = 0; i < 8; i++) begin
            if (cyc % TP >= TP - TL) chk("thr_flags", {o_rxf_n, o_txe_n}, 2'b11);
            step();
        end
        chk("thr_pops", pops, 6);
        idle_inputs();
`endif

        // Random phase against the model.
        for (int i = 0; i < 600; i++) begin
            oe_n     = ($urandom_range(3) == 0);
            rd_n     = ($urandom_range(2) == 0);
            wr_n     = ($urandom_range(1) == 0) || !oe_n;
            dn_valid = ($urandom_range(2) != 0);
            up_ready = ($urandom_range(1) == 0);
            dn_data  = 8'($urandom);
            data_i   = 8'($urandom);
            step();
        end
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
